// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - PS/2 frame layout, receiver state encoding and protocol constants
package ps2_pkg;

    localparam int FRAME_BITS = 11;
    localparam int START_BIT  = 0;
    localparam int DATA_LSB   = 1;
    localparam int DATA_MSB   = 8;
    localparam int PARITY_BIT = 9;
    localparam int STOP_BIT   = 10;

    localparam logic [7:0] ACK          = 8'hFA;
    localparam logic [7:0] BAT_OK       = 8'hAA;
    localparam logic [7:0] MOUSE_ID     = 8'h00;
    localparam logic [7:0] EN_REPORTING = 8'hF4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } rx_state_t;

    // Odd parity: data plus parity bit must carry an odd number of ones.
    function automatic logic frame_err(input logic [FRAME_BITS-1:0] f);
        return (f[START_BIT] != 1'b0) || (f[STOP_BIT] != 1'b1) || !(^f[PARITY_BIT:DATA_LSB]);
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// rtl/ps2_clk_filter.sv - pad synchronizers, ps2_clk glitch filter and falling-edge strobe
module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk_25MHz,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic fall_edge,
    output logic data_sample
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic [CW-1:0] run_cnt;
    logic          clk_filt;

    // The filtered clock flips only after the synchronized clock has disagreed
    // with it for FILTER_LEN consecutive cycles; data is captured on that flip.
    always_ff @(posedge clk_25MHz or posedge reset) begin
        if (reset) begin
            clk_sync    <= 2'b11;
            data_sync   <= 2'b11;
            run_cnt     <= '0;
            clk_filt    <= 1'b1;
            fall_edge   <= 1'b0;
            data_sample <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            fall_edge <= 1'b0;
            if (clk_sync[1] != clk_filt) begin
                if (run_cnt == CW'(FILTER_LEN - 1)) begin
                    run_cnt  <= '0;
                    clk_filt <= clk_sync[1];
                    if (!clk_sync[1]) begin
                        fall_edge   <= 1'b1;
                        data_sample <= data_sync[1];
                    end
                end else begin
                    run_cnt <= run_cnt + 1'b1;
                end
            end else begin
                run_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 device-to-host frame receiver with timeout and inhibit
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic                  clk_25MHz,
    input  logic                  reset,
    input  logic                  ps2_clk,
    input  logic                  ps2_data,
    input  logic                  rx_inhibit,
    output logic [FRAME_BITS-1:0] rx_data,
    output logic                  data_flag,
    output logic                  err,
    output logic                  busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    rx_state_t             state, state_next;
    logic                  fall_edge;
    logic                  data_sample;
    logic [FRAME_BITS-1:0] shift_reg;
    logic [FRAME_BITS-1:0] shift_next;
    logic [3:0]            bit_cnt;
    logic [TW-1:0]         tmo_cnt;
    logic                  tmo_hit;

    ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk_25MHz   (clk_25MHz),
        .reset       (reset),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .fall_edge   (fall_edge),
        .data_sample (data_sample)
    );

    assign shift_next = {data_sample, shift_reg[FRAME_BITS-1:1]};
    assign tmo_hit    = (tmo_cnt == TW'(TIMEOUT_CYCLES));
    assign busy       = (state == SHIFT);
    assign data_flag  = (state == DONE);

    always_ff @(posedge clk_25MHz or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (fall_edge) state_next = SHIFT;
            SHIFT: begin
                if (fall_edge && bit_cnt == 4'(FRAME_BITS - 1)) begin
                    state_next = DONE;
                end else if (tmo_hit) begin
                    state_next = IDLE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // A frame already in DONE is complete and still gets reported.
        if (rx_inhibit && state != DONE) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk_25MHz or posedge reset) begin
        if (reset) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            tmo_cnt   <= '0;
            rx_data   <= '0;
            err       <= 1'b0;
        end else begin
            if (fall_edge && state_next != IDLE) begin
                shift_reg <= shift_next;
                bit_cnt   <= bit_cnt + 1'b1;
            end else if (state_next == IDLE) begin
                bit_cnt <= '0;
            end

            if (state == SHIFT && !fall_edge) begin
                if (!tmo_hit) tmo_cnt <= tmo_cnt + 1'b1;
            end else begin
                tmo_cnt <= '0;
            end

            // Load on the 11th edge so rx_data is valid during the DONE cycle.
            if (state == SHIFT && state_next == DONE) begin
                rx_data <= shift_next;
                err     <= frame_err(shift_next);
            end
        end
    end

endmodule

// File: tb/tb_ps2_rx.sv
// tb/tb_ps2_rx.sv - directed table-driven bench for ps2_rx
module tb_ps2_rx;
    import ps2_pkg::*;

    localparam int FILTER_LEN     = 8;
    localparam int TIMEOUT_CYCLES = 5000;
    localparam int FAST           = 40;
    localparam int SLOW           = 1000;

    logic        clk_25MHz = 1'b0;
    logic        reset;
    logic        ps2_clk;
    logic        ps2_data;
    logic        rx_inhibit;
    logic [10:0] rx_data;
    logic        data_flag;
    logic        err;
    logic        busy;

    int   n_checks  = 0;
    int   n_fail    = 0;
    int   cyc       = 0;
    int   flag_cnt  = 0;
    int   flag_dbl  = 0;
    int   flag_cyc  = 0;
    int   busy_gap  = 0;
    int   last_fall = 0;
    logic prev_flag = 1'b0;

    typedef struct {
        string       name;
        logic [7:0]  data;
        logic        par;
        logic        stop;
        int          half;
        int          glitch;
        logic [10:0] exp_rx;
        logic        exp_err;
    } vec_t;

    vec_t vecs[5];

    ps2_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .clk_25MHz  (clk_25MHz),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rx_inhibit (rx_inhibit),
        .rx_data    (rx_data),
        .data_flag  (data_flag),
        .err        (err),
        .busy       (busy)
    );

    always #20 clk_25MHz = ~clk_25MHz;

    always @(posedge clk_25MHz) cyc <= cyc + 1;

    always @(negedge clk_25MHz) begin
        if (data_flag) begin
            flag_cnt = flag_cnt + 1;
            flag_cyc = cyc;
            if (prev_flag) flag_dbl = flag_dbl + 1;
        end
        prev_flag = data_flag;
    end

    initial begin
        repeat (90000) @(posedge clk_25MHz);
        $display("FAIL watchdog: simulation exceeded 90000 cycles");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk_25MHz);
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic p, input logic s);
        return {s, p, d, 1'b0};
    endfunction

    // Device-side driver: data changes while ps2_clk is high, host samples on the fall.
    task automatic send_bits(input logic [10:0] bits, input int nbits, input int half, input int glitch_bit);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            if (i == glitch_bit) begin
                wait_cycles(half / 2);
                ps2_clk = 1'b0;
                wait_cycles(3);
                ps2_clk = 1'b1;
                wait_cycles(half - half / 2 - 3);
            end else begin
                wait_cycles(half);
            end
            if (i > 0 && !busy) busy_gap++;
            ps2_clk   = 1'b0;
            last_fall = cyc;
            wait_cycles(half);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    initial begin
        int fc0;
        int dbl0;
        logic [10:0] bits;

        vecs[0] = '{"ack_slow",     ACK,      1'b1, 1'b1, SLOW, -1, 11'b11111110100, 1'b0};
        vecs[1] = '{"id_bad_par",   MOUSE_ID, 1'b0, 1'b1, FAST, -1, 11'b10000000000, 1'b1};
        vecs[2] = '{"id_good_par",  MOUSE_ID, 1'b1, 1'b1, FAST, -1, 11'b11000000000, 1'b0};
        vecs[3] = '{"bat_glitch",   BAT_OK,   1'b1, 1'b1, FAST,  5, 11'b11101010100, 1'b0};
        vecs[4] = '{"bat_bad_stop", BAT_OK,   1'b1, 1'b0, FAST, -1, 11'b01101010100, 1'b1};

        reset      = 1'b1;
        ps2_clk    = 1'b1;
        ps2_data   = 1'b1;
        rx_inhibit = 1'b0;
        wait_cycles(5);
        check("reset rx_data",   32'(rx_data),   32'h0);
        check("reset data_flag", 32'(data_flag), 32'h0);
        check("reset err",       32'(err),       32'h0);
        check("reset busy",      32'(busy),      32'h0);
        reset = 1'b0;
        wait_cycles(20);

        for (int i = 0; i < 5; i++) begin
            fc0      = flag_cnt;
            dbl0     = flag_dbl;
            busy_gap = 0;
            send_bits(mk_frame(vecs[i].data, vecs[i].par, vecs[i].stop), 11, vecs[i].half, vecs[i].glitch);
            wait_cycles(20);
            check($sformatf("%s flag_count", vecs[i].name), 32'(flag_cnt - fc0), 32'd1);
            check($sformatf("%s flag_width", vecs[i].name), 32'(flag_dbl - dbl0), 32'd0);
            check($sformatf("%s rx_data", vecs[i].name),    32'(rx_data),         32'(vecs[i].exp_rx));
            check($sformatf("%s err", vecs[i].name),        32'(err),             32'(vecs[i].exp_err));
            check($sformatf("%s busy_frame", vecs[i].name), 32'(busy_gap),        32'd0);
            check($sformatf("%s busy_after", vecs[i].name), 32'(busy),            32'd0);
            if (i == 0) begin
                // 2 sync + FILTER_LEN filter cycles to the edge strobe, then 1 to data_flag
                check("ack_slow latency", 32'(flag_cyc - last_fall), 32'(3 + FILTER_LEN));
            end
        end

        // Clock stops after 5 bits: timeout must abandon the frame silently.
        fc0 = flag_cnt;
        send_bits(mk_frame(EN_REPORTING, 1'b0, 1'b1), 5, FAST, -1);
        wait_cycles(4800);
        check("timeout busy_before", 32'(busy), 32'd1);
        wait_cycles(400);
        check("timeout busy_after", 32'(busy),           32'd0);
        check("timeout no_flag",    32'(flag_cnt - fc0), 32'd0);
        check("timeout rx_hold",    32'(rx_data),        32'(11'b01101010100));
        check("timeout err_hold",   32'(err),            32'd1);
        send_bits(mk_frame(EN_REPORTING, 1'b0, 1'b1), 11, FAST, -1);
        wait_cycles(20);
        check("en_rep flag_count", 32'(flag_cnt - fc0), 32'd1);
        check("en_rep rx_data",    32'(rx_data),        32'(11'b10111101000));
        check("en_rep err",        32'(err),            32'd0);

        // Inhibit after 4 bits: partial frame and any edges while inhibited are dropped.
        fc0  = flag_cnt;
        bits = mk_frame(ACK, 1'b1, 1'b1);
        send_bits(bits, 4, FAST, -1);
        rx_inhibit = 1'b1;
        wait_cycles(5);
        check("inhibit busy", 32'(busy), 32'd0);
        send_bits(bits >> 4, 7, FAST, -1);
        wait_cycles(20);
        check("inhibit busy_hold", 32'(busy),           32'd0);
        rx_inhibit = 1'b0;
        wait_cycles(20);
        check("inhibit no_flag",   32'(flag_cnt - fc0), 32'd0);
        check("inhibit rx_hold",   32'(rx_data),        32'(11'b10111101000));
        send_bits(bits, 11, FAST, -1);
        wait_cycles(20);
        check("post_inhibit flag_count", 32'(flag_cnt - fc0), 32'd1);
        check("post_inhibit rx_data",    32'(rx_data),        32'(11'b11111110100));
        check("post_inhibit err",        32'(err),            32'd0);

        // Reset after 6 bits: outputs clear immediately, no frame reported.
        fc0 = flag_cnt;
        send_bits(mk_frame(BAT_OK, 1'b1, 1'b1), 6, FAST, -1);
        check("pre_reset busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("async_reset rx_data",   32'(rx_data),   32'h0);
        check("async_reset data_flag", 32'(data_flag), 32'h0);
        check("async_reset err",       32'(err),       32'h0);
        check("async_reset busy",      32'(busy),      32'h0);
        wait_cycles(3);
        reset = 1'b0;
        wait_cycles(20);
        check("reset no_flag", 32'(flag_cnt - fc0), 32'd0);
        send_bits(mk_frame(MOUSE_ID, 1'b1, 1'b1), 11, FAST, -1);
        wait_cycles(20);
        check("post_reset flag_count", 32'(flag_cnt - fc0), 32'd1);
        check("post_reset rx_data",    32'(rx_data),        32'(11'b11000000000));
        check("post_reset err",        32'(err),            32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
